// File: rtl/bank_seq.sv
// Bank access sequencer: arm, write DEPTH rows, bit-reversed read sweep, optional CAM phase and second sweep.
// Optional feature macro: BANK_SEQ_CAM_EN enables the CAM and READ2 phases.
`timescale 1ns/1ps
module bank_seq #(
  parameter int WORD_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int QUERY_W    = 4,
  parameter int CAM_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [QUERY_W-1:0] query_in,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [WORD_W-1:0]  word,
  output logic [ADDR_W-1:0]  addr,
  output logic [QUERY_W-1:0] query,
  output logic               MAC_en,
  output logic               w_en,
  output logic               read_bar,
  output logic               CS,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, ARM, WRITE, READ1, CAM, READ2, DONE} state_t;

  generate
    if (CAM_CYCLES < 1 || CAM_CYCLES > 255) begin : g_bad_cam_cycles
      $error("bank_seq: CAM_CYCLES must be within 1..255");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   cnt_rev;
  logic [WORD_W-1:0]   word_reg, word_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [QUERY_W-1:0]  query_reg, query_next;
  logic                mac_en_reg, mac_en_next;
  logic                w_en_reg, w_en_next;
  logic                read_bar_reg, read_bar_next;
  logic                cs_reg, cs_next;
  logic                done_reg, done_next;

  // Read sweep visits rows in bit-reversed counter order.
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_rev
      assign cnt_rev[gi] = cnt_reg[ADDR_W-1-gi];
    end
  endgenerate

`ifdef BANK_SEQ_CAM_EN
  logic [QUERY_W-1:0] query_lat_reg, query_lat_next;
  logic [7:0]         cam_cnt_reg, cam_cnt_next;
  localparam logic [7:0] CAM_LAST = 8'(CAM_CYCLES - 1);
`else
  logic unused_query;
  assign unused_query = ^query_in;
`endif

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    word_next     = word_reg;
    addr_next     = addr_reg;
    query_next    = '1;
    mac_en_next   = 1'b1;
    w_en_next     = 1'b0;
    read_bar_next = read_bar_reg;
    cs_next       = 1'b1;
    done_next     = 1'b0;
`ifdef BANK_SEQ_CAM_EN
    query_lat_next = query_lat_reg;
    cam_cnt_next   = cam_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        cs_next       = 1'b0;
        addr_next     = '0;
        read_bar_next = 1'b0;
        cnt_next      = '0;
        if (start) begin
          state_next = ARM;
`ifdef BANK_SEQ_CAM_EN
          query_lat_next = query_in;
`endif
        end
      end
      ARM: begin
        cnt_next   = '0;
        state_next = WRITE;
      end
      WRITE: begin
        read_bar_next = 1'b0;
        if (wr_valid) begin
          w_en_next = 1'b1;
          word_next = wr_data;
          addr_next = cnt_reg;
          if (cnt_reg == LAST_ROW) begin
            cnt_next   = '0;
            state_next = READ1;
          end else begin
            cnt_next = cnt_reg + ADDR_W'(1);
          end
        end
      end
      READ1: begin
        addr_next     = cnt_rev;
        read_bar_next = cnt_reg[0];
        if (cnt_reg == LAST_ROW) begin
          cnt_next = '0;
`ifdef BANK_SEQ_CAM_EN
          state_next = CAM;
`else
          state_next = DONE;
`endif
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
`ifdef BANK_SEQ_CAM_EN
      CAM: begin
        mac_en_next = 1'b0;
        query_next  = query_lat_reg;
        if (cam_cnt_reg == CAM_LAST) begin
          cam_cnt_next = '0;
          state_next   = READ2;
        end else begin
          cam_cnt_next = cam_cnt_reg + 8'd1;
        end
      end
      READ2: begin
        addr_next     = cnt_rev;
        read_bar_next = cnt_reg[0];
        if (cnt_reg == LAST_ROW) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
`endif
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      word_reg     <= '0;
      addr_reg     <= '0;
      query_reg    <= '1;
      mac_en_reg   <= 1'b1;
      w_en_reg     <= 1'b0;
      read_bar_reg <= 1'b0;
      cs_reg       <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      word_reg     <= word_next;
      addr_reg     <= addr_next;
      query_reg    <= query_next;
      mac_en_reg   <= mac_en_next;
      w_en_reg     <= w_en_next;
      read_bar_reg <= read_bar_next;
      cs_reg       <= cs_next;
      done_reg     <= done_next;
    end
  end

`ifdef BANK_SEQ_CAM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query_lat_reg <= '0;
      cam_cnt_reg   <= '0;
    end else begin
      query_lat_reg <= query_lat_next;
      cam_cnt_reg   <= cam_cnt_next;
    end
  end
`endif

  // Bank-facing outputs show the command issued by the state of the previous cycle.
  assign word     = word_reg;
  assign addr     = addr_reg;
  assign query    = query_reg;
  assign MAC_en   = mac_en_reg;
  assign w_en     = w_en_reg;
  assign read_bar = read_bar_reg;
  assign CS       = cs_reg;
  assign done     = done_reg;
  assign wr_ready = (state_reg == WRITE);
  assign busy     = (state_reg != IDLE);

endmodule
